poly_key_synth: RTL
===================

# poly_key_synth

Polyphonic successor to the single-tone keyboard synthesiser. It takes PS/2 set-2 scan-code bytes from the keyboard receiver, one byte per `Flag` strobe, and tracks make and break codes per key. It allocates up to `NUM_VOICES` simultaneous square-wave voices and mixes them into a single PWM stream for the board audio amplifier. It sits between the PS/2 byte receiver and the `ampPWM`/`ampSD` pins.

## Interface
- `CLK_HZ`, 100_000_000: `Clock` frequency; tone constants are derived from it at elaboration.
- `NUM_VOICES`, 4: simultaneous voices; must be a power of two, 1..8.
- `PWM_WIDTH`, 8: PWM carrier counter width; carrier period is 2^PWM_WIDTH cycles.
- `HP_WIDTH`, 20: half-period counter width; must hold CLK_HZ/(2*262).

Ports:
- `Clock`  in  1  system clock; the only clock.
- `btnCpuReset`  in  1  reset, synchronous, active-high.
- `KeyCode`  in  8  scan-code byte; valid only while `Flag`=1.
- `Flag`  in  1  one-cycle strobe marking a new `KeyCode` byte.
- `ampPWM`  out  1  mixed PWM audio.
- `ampSD`  out  1  amplifier enable; 1 while any voice is active.
- `ActiveMask`  out  NUM_VOICES  bit v=1 when voice v is allocated.
- `Overflow`  out  1  one-cycle pulse when a make code is dropped because every voice is busy.

## Operation
- Key table (code → note, Hz): 1C→C4 262, 1B→D4 294, 23→E4 330, 2B→F4 349, 34→G4 392, 33→A4 440, 3B→B4 494, 42→C5 523. Any other code is unmapped.
- Half-period per note: HP = floor(CLK_HZ/(2*f)), computed as elaboration constants. No runtime division.
- Decoder FSM, advancing only on cycles with `Flag`=1:
  - IDLE: byte F0 → BREAK; E0 → EXT; any other byte is handled as a make code, stay in IDLE.
  - BREAK: any byte is handled as a break code → IDLE.
  - EXT: F0 → EXT_BREAK; any other byte is discarded → IDLE.
  - EXT_BREAK: any byte is discarded → IDLE.
- Make code handling:
  - Unmapped code: ignored.
  - Key already held by a voice (typematic repeat): ignored, and that voice's phase is not disturbed.
  - Otherwise the lowest-index free voice is allocated: key recorded, half-period counter = 0, square output = 0.
  - No free voice: dropped, `Overflow` pulses.
- Break code handling: every voice holding that key is freed; its square output is forced to 0. Break for a key that is not held: no effect.
- Voice run: the counter increments each cycle. When it reaches HP−1 it returns to 0 and the square output toggles, giving a period of exactly 2*HP cycles.
- Mixer: sum S = number of voices whose square output is 1 (0..NUM_VOICES). Level L = S << (PWM_WIDTH − log2 NUM_VOICES), held in PWM_WIDTH+1 bits.
- PWM: a free-running PWM_WIDTH-bit counter C. `ampPWM` = (C < L), registered. When S = NUM_VOICES, `ampPWM` is constant 1.
- `ampSD` = |ActiveMask, registered.

## Timing
- Reset (synchronous, takes effect at the edge where `btnCpuReset`=1): FSM = IDLE; all voices freed; counters and C = 0. Outputs: `ActiveMask`=0, `ampPWM`=0, `ampSD`=0, `Overflow`=0.
- Reset mid-tone silences every voice at the next edge. Any pending F0/E0 prefix is lost.
- Make byte strobed in cycle N: `ActiveMask` bit set at edge N+1; `ampSD`=1 at edge N+2. First square toggle occurs HP cycles after allocation.
- Break byte strobed in cycle N: bit cleared at edge N+1; `ampSD` falls at N+2 if no voice remains active.
- `Overflow` is high for exactly cycle N+1.
- `ampPWM` lags the square outputs by 1 cycle.
- A `Flag` in every cycle is supported; each byte is consumed in its own cycle.

## Test plan
- CLK_HZ=1_000_000: reset, then Flag with 33 → `ActiveMask`=0001 one cycle later. Voice 0 toggles every 1136 cycles (period 2272). `ampPWM` duty is 64/256 while voice 0 is high and 0 while it is low. `ampSD`=1.
- Make 1C, 23, 34, 42, then 3B → voices 0–3 allocated in that order. 3B produces an `Overflow` pulse; `ActiveMask`=1111.
- Make 23, then F0,23 → voice 0 allocated, then freed one cycle after the 23 byte. `ampSD` is back to 0 two cycles after that byte.
- Make 1C three times (typematic repeat) → only voice 0 is allocated; its toggle spacing is uninterrupted at 1908 cycles.
- E0 then 1C, and separately make 0D → no allocation, FSM returns to IDLE. A following 1C allocates normally.
- Reset asserted while 3 voices are sounding → next edge `ActiveMask`=0 and `ampPWM`=0. A pending F0 prefix is cleared, so a following 33 is treated as a make.

Source files
------------

// File: rtl/poly_key_synth.sv
// Polyphonic PS/2 keyboard synth: make/break decode, voice allocation, square-wave voices, PWM mix.
// Outputs are registered; one byte per Flag strobe, every cycle, no backpressure.
module poly_key_synth #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NUM_VOICES = 4,
  parameter int PWM_WIDTH  = 8,
  parameter int HP_WIDTH   = 20
) (
  input  logic                  Clock,
  input  logic                  btnCpuReset,
  input  logic [7:0]            KeyCode,
  input  logic                  Flag,
  output logic                  ampPWM,
  output logic                  ampSD,
  output logic [NUM_VOICES-1:0] ActiveMask,
  output logic                  Overflow
);
  localparam int VSHIFT    = $clog2(NUM_VOICES);
  localparam int VIDX_W    = (VSHIFT > 0) ? VSHIFT : 1;
  localparam int SUM_W     = VSHIFT + 1;
  localparam int LVL_W     = PWM_WIDTH + 1;
  localparam int LVL_SHIFT = PWM_WIDTH - VSHIFT;

  localparam logic [HP_WIDTH-1:0] HP_C4 = HP_WIDTH'(CLK_HZ / (2 * 262));
  localparam logic [HP_WIDTH-1:0] HP_D4 = HP_WIDTH'(CLK_HZ / (2 * 294));
  localparam logic [HP_WIDTH-1:0] HP_E4 = HP_WIDTH'(CLK_HZ / (2 * 330));
  localparam logic [HP_WIDTH-1:0] HP_F4 = HP_WIDTH'(CLK_HZ / (2 * 349));
  localparam logic [HP_WIDTH-1:0] HP_G4 = HP_WIDTH'(CLK_HZ / (2 * 392));
  localparam logic [HP_WIDTH-1:0] HP_A4 = HP_WIDTH'(CLK_HZ / (2 * 440));
  localparam logic [HP_WIDTH-1:0] HP_B4 = HP_WIDTH'(CLK_HZ / (2 * 494));
  localparam logic [HP_WIDTH-1:0] HP_C5 = HP_WIDTH'(CLK_HZ / (2 * 523));

  typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_EXT, ST_EXT_BREAK} state_t;

  // Returns {mapped, note index}
  function automatic logic [3:0] decode_note(input logic [7:0] code);
    case (code)
      8'h1C:   return 4'b1_000;
      8'h1B:   return 4'b1_001;
      8'h23:   return 4'b1_010;
      8'h2B:   return 4'b1_011;
      8'h34:   return 4'b1_100;
      8'h33:   return 4'b1_101;
      8'h3B:   return 4'b1_110;
      8'h42:   return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

  function automatic logic [HP_WIDTH-1:0] hp_of(input logic [2:0] n);
    case (n)
      3'd0:    return HP_C4;
      3'd1:    return HP_D4;
      3'd2:    return HP_E4;
      3'd3:    return HP_F4;
      3'd4:    return HP_G4;
      3'd5:    return HP_A4;
      3'd6:    return HP_B4;
      default: return HP_C5;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [NUM_VOICES-1:0]   act_q, act_d, sq_q, sq_d;
  logic [2:0]              note_q [NUM_VOICES];
  logic [2:0]              note_d [NUM_VOICES];
  logic [HP_WIDTH-1:0]     cnt_q  [NUM_VOICES];
  logic [HP_WIDTH-1:0]     cnt_d  [NUM_VOICES];
  logic [PWM_WIDTH-1:0]    pwm_cnt_q;
  logic                    pwm_q, pwm_d, sd_q, ovf_q, ovf_d;

  logic                    key_mapped;
  logic [2:0]              key_note;
  logic                    is_make, is_break, do_alloc, do_free, free_found;
  logic [NUM_VOICES-1:0]   held;
  logic [VIDX_W-1:0]       free_idx;
  logic [SUM_W-1:0]        sum;
  logic [LVL_W-1:0]        level;

  assign {key_mapped, key_note} = decode_note(KeyCode);
  assign is_make  = Flag && (state_q == ST_IDLE) && (KeyCode != 8'hF0) && (KeyCode != 8'hE0);
  assign is_break = Flag && (state_q == ST_BREAK);

  always_comb begin
    state_d = state_q;
    if (Flag) begin
      case (state_q)
        ST_IDLE: begin
          if (KeyCode == 8'hF0)      state_d = ST_BREAK;
          else if (KeyCode == 8'hE0) state_d = ST_EXT;
        end
        ST_EXT:  state_d = (KeyCode == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A key already held is never allocated twice, so held has at most one bit set
  always_comb begin
    held       = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      held[v] = act_q[v] && (note_q[v] == key_note);
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!act_q[v]) begin
        free_found = 1'b1;
        free_idx   = VIDX_W'(v);
      end
    end
  end

  assign do_alloc = is_make && key_mapped && !(|held) && free_found;
  assign ovf_d    = is_make && key_mapped && !(|held) && !free_found;
  assign do_free  = is_break && key_mapped;

  always_comb begin
    act_d = act_q;
    sq_d  = sq_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      note_d[v] = note_q[v];
      cnt_d[v]  = '0;
      if (act_q[v]) begin
        if (cnt_q[v] == hp_of(note_q[v]) - HP_WIDTH'(1)) sq_d[v] = ~sq_q[v];
        else                                             cnt_d[v] = cnt_q[v] + HP_WIDTH'(1);
      end else begin
        sq_d[v] = 1'b0;
      end
      if (do_free && held[v]) begin
        act_d[v] = 1'b0;
        sq_d[v]  = 1'b0;
        cnt_d[v] = '0;
      end
      if (do_alloc && (free_idx == VIDX_W'(v))) begin
        act_d[v]  = 1'b1;
        sq_d[v]   = 1'b0;
        cnt_d[v]  = '0;
        note_d[v] = key_note;
      end
    end
  end

  // Full-scale level is 2^PWM_WIDTH, so all voices high holds ampPWM at 1
  always_comb begin
    sum = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      sum = sum + SUM_W'(sq_q[v]);
    level = LVL_W'(sum) << LVL_SHIFT;
    pwm_d = ({1'b0, pwm_cnt_q} < level);
  end

  always_ff @(posedge Clock) begin
    if (btnCpuReset) begin
      state_q   <= ST_IDLE;
      act_q     <= '0;
      sq_q      <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
      sd_q      <= 1'b0;
      ovf_q     <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        cnt_q[v]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      sq_q      <= sq_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_WIDTH'(1);
      pwm_q     <= pwm_d;
      sd_q      <= |act_q;
      ovf_q     <= ovf_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= note_d[v];
        cnt_q[v]  <= cnt_d[v];
      end
    end
  end

  assign ActiveMask = act_q;
  assign ampPWM     = pwm_q;
  assign ampSD      = sd_q;
  assign Overflow   = ovf_q;
endmodule
